// File: rtl/alu_seq_n_if.sv
// Command/result handshake bundle for alu_seq_n: valid/ready on the command side and
// on the result side, plus the registered result and status flags.
interface alu_seq_n_if #(
   parameter int unsigned N = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [2*N+3:0]   command;
   logic             out_valid;
   logic             out_ready;
   logic [N-1:0]     res;
   logic [N-1:0]     res_hi;
   logic             flag_z;
   logic             flag_c;
   logic             flag_dz;

   // Command producer / result consumer side
   modport master (
      output in_valid,
      output command,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  res,
      input  res_hi,
      input  flag_z,
      input  flag_c,
      input  flag_dz
   );

   // ALU side
   modport slave (
      input  in_valid,
      input  command,
      input  out_ready,
      output in_ready,
      output out_valid,
      output res,
      output res_hi,
      output flag_z,
      output flag_c,
      output flag_dz
   );
endinterface

// File: rtl/alu_seq_n.sv
// Sequential N-bit ALU with valid/ready handshake; MUL and DIV iterate one bit per cycle,
// every other function completes in the acceptance cycle. Result is held until taken.
module alu_seq_n #(
   parameter int unsigned N = 8
) (
   input logic        clk,
   input logic        rst_n,
   alu_seq_n_if.slave bus
);
   localparam int unsigned CntW = $clog2(N);

   localparam logic [3:0] FnAdd   = 4'd0;
   localparam logic [3:0] FnSub   = 4'd1;
   localparam logic [3:0] FnMul   = 4'd2;
   localparam logic [3:0] FnDiv   = 4'd3;
   localparam logic [3:0] FnAnd   = 4'd4;
   localparam logic [3:0] FnOr    = 4'd5;
   localparam logic [3:0] FnXor   = 4'd6;
   localparam logic [3:0] FnNot   = 4'd7;
   localparam logic [3:0] FnPassA = 4'd8;
   localparam logic [3:0] FnPassB = 4'd9;
   localparam logic [3:0] FnSll   = 4'd10;
   localparam logic [3:0] FnSrl   = 4'd11;
   localparam logic [3:0] FnSra   = 4'd12;
   localparam logic [3:0] FnInc   = 4'd13;
   localparam logic [3:0] FnDec   = 4'd14;

   typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

   state_e          state_q, state_d;
   logic [N-1:0]    res_q, res_d;
   logic [N-1:0]    res_hi_q, res_hi_d;
   logic [N-1:0]    a_q, a_d;
   logic [N-1:0]    b_q, b_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            flag_z_q, flag_z_d;
   logic            flag_c_q, flag_c_d;
   logic            flag_dz_q, flag_dz_d;

   logic [3:0]      func;
   logic [N-1:0]    op_a, op_b;
   logic [N-1:0]    alu_res;
   logic            alu_c;
   logic [N:0]      add_ext;
   logic [N:0]      mul_sum;
   logic [N:0]      div_shift;
   logic [N-1:0]    div_diff;
   logic            last_iter;

   assign func      = bus.command[2*N+3:2*N];
   assign op_a      = bus.command[2*N-1:N];
   assign op_b      = bus.command[N-1:0];
   assign last_iter = (cnt_q == '0);

   // Single-cycle functions, evaluated straight from the command bus
   always_comb begin
      alu_res = '0;
      alu_c   = 1'b0;
      add_ext = '0;
      case (func)
         FnAdd: begin
            add_ext = {1'b0, op_a} + {1'b0, op_b};
            alu_res = add_ext[N-1:0];
            alu_c   = add_ext[N];
         end
         FnSub: begin
            alu_res = op_a - op_b;
            alu_c   = (op_a < op_b);
         end
         FnAnd:   alu_res = op_a & op_b;
         FnOr:    alu_res = op_a | op_b;
         FnXor:   alu_res = op_a ^ op_b;
         FnNot:   alu_res = ~op_a;
         FnPassA: alu_res = op_a;
         FnPassB: alu_res = op_b;
         FnSll:   alu_res = op_a << op_b;
         FnSrl:   alu_res = op_a >> op_b;
         FnSra:   alu_res = $unsigned($signed(op_a) >>> op_b);
         FnInc: begin
            alu_res = op_a + N'(1);
            alu_c   = &op_a;
         end
         FnDec: begin
            alu_res = op_a - N'(1);
            alu_c   = ~|op_a;
         end
         FnMul, FnDiv: alu_res = '0;
         default: begin
            for (int unsigned i = 0; i < N; i++) begin
               alu_res = alu_res + N'(op_a[i]);
            end
         end
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle: begin
            if (bus.in_valid) begin
               if (func == FnMul) begin
                  state_d = StMul;
               end else if (func == FnDiv) begin
                  state_d = StDiv;
               end else begin
                  state_d = StDone;
               end
            end
         end
         StMul, StDiv: begin
            if (last_iter) begin
               state_d = StDone;
            end
         end
         StDone: begin
            if (bus.out_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Datapath next-state: MUL keeps {res_hi, res} as {partial product, multiplier},
   // DIV keeps {res_hi, res} as {partial remainder, dividend/quotient}.
   always_comb begin
      res_d     = res_q;
      res_hi_d  = res_hi_q;
      a_d       = a_q;
      b_d       = b_q;
      cnt_d     = cnt_q;
      flag_z_d  = flag_z_q;
      flag_c_d  = flag_c_q;
      flag_dz_d = flag_dz_q;
      mul_sum   = {1'b0, res_hi_q} + (res_q[0] ? {1'b0, a_q} : '0);
      div_shift = {res_hi_q, res_q[N-1]};
      div_diff  = div_shift[N-1:0] - b_q;
      case (state_q)
         StIdle: begin
            if (bus.in_valid) begin
               a_d      = op_a;
               b_d      = op_b;
               cnt_d    = CntW'(N - 1);
               res_hi_d = '0;
               if (func == FnMul) begin
                  res_d = op_b;
               end else if (func == FnDiv) begin
                  res_d = op_a;
               end else begin
                  res_d     = alu_res;
                  flag_z_d  = (alu_res == '0);
                  flag_c_d  = alu_c;
                  flag_dz_d = 1'b0;
               end
            end
         end
         StMul: begin
            {res_hi_d, res_d} = {mul_sum, res_q[N-1:1]};
            cnt_d             = cnt_q - CntW'(1);
            if (last_iter) begin
               flag_z_d  = (res_d == '0);
               flag_c_d  = (res_hi_d != '0);
               flag_dz_d = 1'b0;
            end
         end
         StDiv: begin
            // A zero divisor always "fits", giving an all-ones quotient and remainder A
            if (div_shift >= {1'b0, b_q}) begin
               res_hi_d = div_diff;
               res_d    = {res_q[N-2:0], 1'b1};
            end else begin
               res_hi_d = div_shift[N-1:0];
               res_d    = {res_q[N-2:0], 1'b0};
            end
            cnt_d = cnt_q - CntW'(1);
            if (last_iter) begin
               flag_z_d  = (res_d == '0);
               flag_c_d  = 1'b0;
               flag_dz_d = (b_q == '0);
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_q     <= '0;
         res_hi_q  <= '0;
         a_q       <= '0;
         b_q       <= '0;
         cnt_q     <= '0;
         flag_z_q  <= 1'b0;
         flag_c_q  <= 1'b0;
         flag_dz_q <= 1'b0;
      end else begin
         res_q     <= res_d;
         res_hi_q  <= res_hi_d;
         a_q       <= a_d;
         b_q       <= b_d;
         cnt_q     <= cnt_d;
         flag_z_q  <= flag_z_d;
         flag_c_q  <= flag_c_d;
         flag_dz_q <= flag_dz_d;
      end
   end

   // Outputs
   always_comb begin
      bus.in_ready  = (state_q == StIdle);
      bus.out_valid = (state_q == StDone);
      bus.res       = res_q;
      bus.res_hi    = res_hi_q;
      bus.flag_z    = flag_z_q;
      bus.flag_c    = flag_c_q;
      bus.flag_dz   = flag_dz_q;
   end
endmodule
